antares_mem_lsu: RTL and testbench
==================================

ANTARES_MEM_LSU -- requirements
Module: antares_mem_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus watchdog limit in cycles, used only when ANTARES_LSU_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_address  input  32  byte address from EX/MEM (ALU result).
REQ-005 SHALL have port mem_store_data  input  32  store source register.
REQ-006 SHALL have ports mem_read, mem_write, mem_byte, mem_halfword, mem_sign_ext  input  1 each  access type; word when byte=halfword=0.
REQ-007 SHALL have port mem_flush  input  1  current MEM instruction squashed.
REQ-008 SHALL have port mem_stall  input  1  pipeline held by a later stage.
REQ-009 SHALL have ports dport_address output 32, dport_data_o output 32, dport_wr output 4, dport_enable output 1  data bus request.
REQ-010 SHALL have ports dport_data_i input 32, dport_ready input 1, dport_error input 1  data bus response.
REQ-011 SHALL have ports mem_read_data output 32, mem_request_stall output 1, exc_address_l output 1, exc_address_s output 1, exc_bus_error output 1.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 Request SHALL be valid in IDLE when (mem_read|mem_write) & ~mem_flush & aligned; word aligned iff address[1:0]=0, halfword iff address[0]=0, byte always.
REQ-014 Misaligned request SHALL assert exc_address_l (read) or exc_address_s (write) combinationally in IDLE, issue no bus cycle, and not stall.
REQ-015 Valid request SHALL register dport_address={address[31:2],2'b00}, dport_data_o, dport_wr, and enter BUSY next cycle with dport_enable=1.
REQ-016 Byte lanes SHALL be big-endian: byte at offset 0..3 -> dport_wr 1000/0100/0010/0001; halfword offset 0/2 -> 1100/0011; word -> 1111; read -> 0000.
REQ-017 Store data SHALL be replicated: byte {4{d[7:0]}}, halfword {2{d[15:0]}}, word d.
REQ-018 BUSY SHALL hold all dport outputs stable until dport_ready=1 or dport_error=1, then deassert dport_enable and enter DONE.
REQ-019 On ready, load data SHALL be lane-selected by address[1:0] and sign-extended if mem_sign_ext else zero-extended, then registered into mem_read_data.
REQ-020 dport_error in BUSY SHALL pulse exc_bus_error one cycle, set mem_read_data=0, enter DONE; error takes priority over simultaneous ready.
REQ-021 mem_request_stall SHALL equal (IDLE & valid request) | BUSY; it SHALL be 0 in DONE.
REQ-022 DONE SHALL hold mem_read_data and return to IDLE on the first cycle with mem_stall=0.
REQ-023 mem_flush during BUSY SHALL NOT abort the bus cycle; completion then goes directly to IDLE with no exception and mem_read_data unchanged.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, dport_enable=0, dport_wr=0, dport_address=0, dport_data_o=0, mem_read_data=0, exc_bus_error=0, watchdog=0.
REQ-025 Reset during BUSY SHALL abandon the bus cycle; the first cycle after release SHALL be IDLE.

Configuration
REQ-026 With macro ANTARES_LSU_TIMEOUT_EN defined, an 8-bit counter SHALL count BUSY cycles and, at TIMEOUT_CYCLES without response, behave exactly as dport_error (REQ-020).
REQ-027 Without ANTARES_LSU_TIMEOUT_EN, no counter SHALL exist and BUSY SHALL wait indefinitely.

Verification
REQ-028 Word load addr 0x100, dport_ready after 3 cycles, data 0xDEADBEEF -> dport_wr=0000, stall high 4 cycles, mem_read_data=0xDEADBEEF.
REQ-029 Signed byte load addr 0x103, data 0x000000F0 -> 0xFFFFFFF0; unsigned -> 0x000000F0.
REQ-030 Halfword store addr 0x202, data 0x1234ABCD -> dport_address=0x200, dport_wr=0011, dport_data_o=0xABCDABCD.
REQ-031 Word load addr 0x101 -> exc_address_l=1, dport_enable never 1, stall 0.
REQ-032 dport_error with dport_ready in BUSY -> exc_bus_error one-cycle pulse, mem_read_data=0; with macro, no response 255 cycles -> same.
REQ-033 mem_flush during BUSY then ready -> FSM to IDLE, no exception; rst low mid-BUSY -> dport_enable=0 immediately.

Source files
------------

// File: rtl/antares_mem_lsu.sv
// Load/store unit: aligns MEM-stage accesses onto a big-endian 32-bit data port.
// Optional bus watchdog enabled by defining ANTARES_LSU_TIMEOUT_EN.
module antares_mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic        mem_halfword,
    input  logic        mem_sign_ext,
    input  logic        mem_flush,
    input  logic        mem_stall,
    output logic [31:0] dport_address,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_wr,
    output logic        dport_enable,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ready,
    input  logic        dport_error,
    output logic [31:0] mem_read_data,
    output logic        mem_request_stall,
    output logic        exc_address_l,
    output logic        exc_address_s,
    output logic        exc_bus_error
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dport_address_q, dport_address_d;
    logic [DW-1:0]   dport_data_o_q, dport_data_o_d;
    logic [3:0]      dport_wr_q, dport_wr_d;
    logic            dport_enable_q, dport_enable_d;
    logic [DW-1:0]   mem_read_data_q, mem_read_data_d;
    logic            exc_bus_error_q, exc_bus_error_d;
    logic [1:0]      offset_q, offset_d;
    logic            byte_q, byte_d;
    logic            half_q, half_d;
    logic            sext_q, sext_d;
    logic            is_read_q, is_read_d;
    logic            flushed_q, flushed_d;

    logic            aligned_c;
    logic            req_c;
    logic            req_valid_c;
    logic [3:0]      lane_mask_c;
    logic [DW-1:0]   store_rep_c;
    logic [7:0]      load_byte_c;
    logic [15:0]     load_half_c;
    logic [DW-1:0]   load_val_c;
    logic            timeout_c;
    logic            bus_fail_c;
    logic            bus_done_c;

    // Request qualification and store formatting from the current MEM instruction
    always_comb begin
        if (mem_byte) begin
            aligned_c = 1'b1;
        end else if (mem_halfword) begin
            aligned_c = ~mem_address[0];
        end else begin
            aligned_c = (mem_address[1:0] == 2'b00);
        end

        if (mem_byte) begin
            lane_mask_c = 4'b1000 >> mem_address[1:0];
            store_rep_c = {4{mem_store_data[7:0]}};
        end else if (mem_halfword) begin
            lane_mask_c = mem_address[1] ? 4'b0011 : 4'b1100;
            store_rep_c = {2{mem_store_data[15:0]}};
        end else begin
            lane_mask_c = 4'b1111;
            store_rep_c = mem_store_data;
        end
    end

    assign req_c       = (mem_read | mem_write) & ~mem_flush;
    assign req_valid_c = (state_q == S_IDLE) & req_c & aligned_c;

    assign exc_address_l     = (state_q == S_IDLE) & mem_read & ~mem_flush & ~aligned_c;
    assign exc_address_s     = (state_q == S_IDLE) & mem_write & ~mem_flush & ~aligned_c;
    assign mem_request_stall = req_valid_c | (state_q == S_BUSY);

    // Big-endian lane extraction using the offset captured at request time
    always_comb begin
        case (offset_q)
            2'd0:    load_byte_c = dport_data_i[31:24];
            2'd1:    load_byte_c = dport_data_i[23:16];
            2'd2:    load_byte_c = dport_data_i[15:8];
            default: load_byte_c = dport_data_i[7:0];
        endcase
        load_half_c = offset_q[1] ? dport_data_i[15:0] : dport_data_i[31:16];

        if (byte_q) begin
            load_val_c = {{24{sext_q & load_byte_c[7]}}, load_byte_c};
        end else if (half_q) begin
            load_val_c = {{16{sext_q & load_half_c[15]}}, load_half_c};
        end else begin
            load_val_c = dport_data_i;
        end
    end

`ifdef ANTARES_LSU_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q, wdog_d;

    // Counts unanswered BUSY cycles; the final one is treated as a bus error
    always_comb begin
        wdog_d    = 8'd0;
        timeout_c = 1'b0;
        if ((state_q == S_BUSY) && !dport_ready && !dport_error) begin
            if (wdog_q == WDOG_LIMIT) begin
                timeout_c = 1'b1;
            end else begin
                wdog_d = wdog_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    assign bus_fail_c = dport_error | timeout_c;
    assign bus_done_c = dport_ready | bus_fail_c;

    // Next-state and registered output logic
    always_comb begin
        state_d         = state_q;
        dport_address_d = dport_address_q;
        dport_data_o_d  = dport_data_o_q;
        dport_wr_d      = dport_wr_q;
        dport_enable_d  = dport_enable_q;
        mem_read_data_d = mem_read_data_q;
        exc_bus_error_d = 1'b0;
        offset_d        = offset_q;
        byte_d          = byte_q;
        half_d          = half_q;
        sext_d          = sext_q;
        is_read_d       = is_read_q;
        flushed_d       = flushed_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_c) begin
                    state_d         = S_BUSY;
                    dport_address_d = {mem_address[31:2], 2'b00};
                    dport_data_o_d  = store_rep_c;
                    dport_wr_d      = mem_write ? lane_mask_c : 4'b0000;
                    dport_enable_d  = 1'b1;
                    offset_d        = mem_address[1:0];
                    byte_d          = mem_byte;
                    half_d          = mem_halfword;
                    sext_d          = mem_sign_ext;
                    is_read_d       = mem_read;
                    flushed_d       = 1'b0;
                end
            end
            S_BUSY: begin
                flushed_d = flushed_q | mem_flush;
                if (bus_done_c) begin
                    dport_enable_d = 1'b0;
                    // A squashed access still completes on the bus but leaves no trace
                    if (flushed_q | mem_flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (bus_fail_c) begin
                            exc_bus_error_d = 1'b1;
                            mem_read_data_d = '0;
                        end else if (is_read_q) begin
                            mem_read_data_d = load_val_c;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!mem_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            dport_address_q <= '0;
            dport_data_o_q  <= '0;
            dport_wr_q      <= 4'b0000;
            dport_enable_q  <= 1'b0;
            mem_read_data_q <= '0;
            exc_bus_error_q <= 1'b0;
            offset_q        <= 2'd0;
            byte_q          <= 1'b0;
            half_q          <= 1'b0;
            sext_q          <= 1'b0;
            is_read_q       <= 1'b0;
            flushed_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            dport_address_q <= dport_address_d;
            dport_data_o_q  <= dport_data_o_d;
            dport_wr_q      <= dport_wr_d;
            dport_enable_q  <= dport_enable_d;
            mem_read_data_q <= mem_read_data_d;
            exc_bus_error_q <= exc_bus_error_d;
            offset_q        <= offset_d;
            byte_q          <= byte_d;
            half_q          <= half_d;
            sext_q          <= sext_d;
            is_read_q       <= is_read_d;
            flushed_q       <= flushed_d;
        end
    end

    assign dport_address = dport_address_q;
    assign dport_data_o  = dport_data_o_q;
    assign dport_wr      = dport_wr_q;
    assign dport_enable  = dport_enable_q;
    assign mem_read_data = mem_read_data_q;
    assign exc_bus_error = exc_bus_error_q;

endmodule

// File: tb/tb_antares_mem_lsu.sv
// Directed bench for antares_mem_lsu: loads, stores, misalignment, bus errors, flush and reset.
module tb_antares_mem_lsu;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_store_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        mem_halfword;
    logic        mem_sign_ext;
    logic        mem_flush;
    logic        mem_stall;
    logic [31:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_wr;
    logic        dport_enable;
    logic [31:0] dport_data_i;
    logic        dport_ready;
    logic        dport_error;
    logic [31:0] mem_read_data;
    logic        mem_request_stall;
    logic        exc_address_l;
    logic        exc_address_s;
    logic        exc_bus_error;

    int n_run;
    int n_fail;
    int stall_cnt;
    logic cnt_en;

    antares_mem_lsu #(.TIMEOUT_CYCLES(255)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_address       (mem_address),
        .mem_store_data    (mem_store_data),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_byte          (mem_byte),
        .mem_halfword      (mem_halfword),
        .mem_sign_ext      (mem_sign_ext),
        .mem_flush         (mem_flush),
        .mem_stall         (mem_stall),
        .dport_address     (dport_address),
        .dport_data_o      (dport_data_o),
        .dport_wr          (dport_wr),
        .dport_enable      (dport_enable),
        .dport_data_i      (dport_data_i),
        .dport_ready       (dport_ready),
        .dport_error       (dport_error),
        .mem_read_data     (mem_read_data),
        .mem_request_stall (mem_request_stall),
        .exc_address_l     (exc_address_l),
        .exc_address_s     (exc_address_s),
        .exc_bus_error     (exc_bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial stall_cnt = 0;
    always @(negedge clk) begin
        if (cnt_en && mem_request_stall) stall_cnt <= stall_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mem_address    = 32'h0;
        mem_store_data = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byte       = 1'b0;
        mem_halfword   = 1'b0;
        mem_sign_ext   = 1'b0;
        mem_flush      = 1'b0;
        mem_stall      = 1'b0;
        dport_data_i   = 32'h0;
        dport_ready    = 1'b0;
        dport_error    = 1'b0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] sd,
                       input logic b, input logic h, input logic s);
        mem_read       = rd;
        mem_write      = wr;
        mem_address    = a;
        mem_store_data = sd;
        mem_byte       = b;
        mem_halfword   = h;
        mem_sign_ext   = s;
    endtask

    // Issue one access, check the bus request, answer after `waits` extra BUSY cycles, stop in DONE
    task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] sd, input logic b, input logic h, input logic s,
                          input logic [31:0] rdata, input logic err, input int waits,
                          input logic [31:0] exp_addr, input logic [3:0] exp_wr,
                          input logic [31:0] exp_do);
        req(rd, wr, a, sd, b, h, s);
        #1;
        chk_b({tag, "_req_stall"}, mem_request_stall, 1'b1);
        step();
        chk_b({tag, "_busy_en"}, dport_enable, 1'b1);
        chk({tag, "_addr"}, dport_address, exp_addr);
        chk({tag, "_wr"}, 32'(dport_wr), 32'(exp_wr));
        chk({tag, "_data_o"}, dport_data_o, exp_do);
        repeat (waits) begin
            step();
            chk_b({tag, "_hold_en"}, dport_enable, 1'b1);
        end
        dport_ready  = 1'b1;
        dport_error  = err;
        dport_data_i = rdata;
        step();
        idle_in();
        #1;
        chk_b({tag, "_done_en"}, dport_enable, 1'b0);
        chk_b({tag, "_done_stall"}, mem_request_stall, 1'b0);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        cnt_en = 1'b0;
        rst    = 1'b0;
        idle_in();

        step();
        chk_b("rst_en", dport_enable, 1'b0);
        chk("rst_wr", 32'(dport_wr), 32'h0);
        chk("rst_addr", dport_address, 32'h0);
        chk("rst_data_o", dport_data_o, 32'h0);
        chk("rst_rdata", mem_read_data, 32'h0);
        chk_b("rst_bus_err", exc_bus_error, 1'b0);
        chk_b("rst_stall", mem_request_stall, 1'b0);
        step();
        rst = 1'b1;
        step();

        // Word load, ready on the third BUSY cycle
        cnt_en = 1'b1;
        access("wload", 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0,
               32'hDEADBEEF, 1'b0, 2, 32'h100, 4'b0000, 32'h0);
        cnt_en = 1'b0;
        chk("wload_rdata", mem_read_data, 32'hDEADBEEF);
        chk("wload_stall_cycles", 32'(stall_cnt), 32'd4);
        step();

        // Signed byte load, then DONE held by mem_stall
        access("sbload", 1'b1, 1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1,
               32'h000000F0, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        chk("sbload_rdata", mem_read_data, 32'hFFFFFFF0);
        mem_stall = 1'b1;
        step();
        req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_b("done_hold_stall", mem_request_stall, 1'b0);
        chk("done_hold_rdata", mem_read_data, 32'hFFFFFFF0);
        idle_in();
        step();

        access("ubload", 1'b1, 1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 1'b0,
               32'h000000F0, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        chk("ubload_rdata", mem_read_data, 32'h000000F0);
        step();

        // Stores: lane masks and replication; read data must not change
        access("hstore", 1'b0, 1'b1, 32'h202, 32'h1234ABCD, 1'b0, 1'b1, 1'b0,
               32'h0, 1'b0, 0, 32'h200, 4'b0011, 32'hABCDABCD);
        chk("hstore_rdata", mem_read_data, 32'h000000F0);
        step();
        access("bstore", 1'b0, 1'b1, 32'h101, 32'h000000EF, 1'b1, 1'b0, 1'b0,
               32'h0, 1'b0, 1, 32'h100, 4'b0100, 32'hEFEFEFEF);
        step();
        access("wstore", 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0,
               32'h0, 1'b0, 0, 32'h104, 4'b1111, 32'hCAFEF00D);
        step();

        // Signed halfword load at offset 2
        access("shload", 1'b1, 1'b0, 32'h302, 32'h0, 1'b0, 1'b1, 1'b1,
               32'h12348001, 1'b0, 0, 32'h300, 4'b0000, 32'h0);
        chk("shload_rdata", mem_read_data, 32'hFFFF8001);
        step();

        // Misaligned accesses
        req(1'b1, 1'b0, 32'h101, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_b("mis_l_exc", exc_address_l, 1'b1);
        chk_b("mis_l_exc_s", exc_address_s, 1'b0);
        chk_b("mis_l_stall", mem_request_stall, 1'b0);
        step();
        chk_b("mis_l_en", dport_enable, 1'b0);
        req(1'b0, 1'b1, 32'h203, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_b("mis_s_exc", exc_address_s, 1'b1);
        chk_b("mis_s_exc_l", exc_address_l, 1'b0);
        chk_b("mis_s_stall", mem_request_stall, 1'b0);
        step();
        chk_b("mis_s_en", dport_enable, 1'b0);
        idle_in();
        step();

        // Bus error wins over simultaneous ready
        access("berr", 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0,
               32'h00000055, 1'b1, 0, 32'h300, 4'b0000, 32'h0);
        chk_b("berr_pulse", exc_bus_error, 1'b1);
        chk("berr_rdata", mem_read_data, 32'h0);
        step();
        chk_b("berr_pulse_end", exc_bus_error, 1'b0);

        // Flush during BUSY: bus cycle completes, result discarded, straight to IDLE
        access("pre_flush", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0,
               32'h11111111, 1'b0, 0, 32'h400, 4'b0000, 32'h0);
        chk("pre_flush_rdata", mem_read_data, 32'h11111111);
        step();
        req(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        mem_flush = 1'b1;
        #1;
        chk_b("flush_en_kept", dport_enable, 1'b1);
        step();
        mem_flush    = 1'b0;
        dport_ready  = 1'b1;
        dport_data_i = 32'h22222222;
        #1;
        chk_b("flush_still_busy", dport_enable, 1'b1);
        step();
        idle_in();
        req(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_b("flush_idle_stall", mem_request_stall, 1'b1);
        chk("flush_rdata", mem_read_data, 32'h11111111);
        chk_b("flush_no_exc", exc_bus_error, 1'b0);
        chk_b("flush_en", dport_enable, 1'b0);

        // Reset in the middle of BUSY
        step();
        chk_b("rbusy_en", dport_enable, 1'b1);
        rst = 1'b0;
        #1;
        chk_b("rbusy_en_drop", dport_enable, 1'b0);
        chk("rbusy_addr", dport_address, 32'h0);
        chk("rbusy_rdata", mem_read_data, 32'h0);
        idle_in();
        step();
        rst = 1'b1;
        req(1'b1, 1'b0, 32'h602, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_b("rbusy_idle_exc", exc_address_l, 1'b1);
        idle_in();
        step();

`ifdef ANTARES_LSU_TIMEOUT_EN
        access("pre_to", 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 1'b0,
               32'h33333333, 1'b0, 0, 32'h104, 4'b0000, 32'h0);
        step();
        req(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        repeat (254) step();
        chk_b("to_last_busy_en", dport_enable, 1'b1);
        chk_b("to_last_busy_exc", exc_bus_error, 1'b0);
        step();
        chk_b("to_pulse", exc_bus_error, 1'b1);
        chk("to_rdata", mem_read_data, 32'h0);
        chk_b("to_en", dport_enable, 1'b0);
        step();
`else
        req(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        idle_in();
        repeat (300) step();
        chk_b("nowd_en", dport_enable, 1'b1);
        chk_b("nowd_exc", exc_bus_error, 1'b0);
        dport_ready  = 1'b1;
        dport_data_i = 32'h77777777;
        step();
        idle_in();
        #1;
        chk("nowd_rdata", mem_read_data, 32'h77777777);
        chk_b("nowd_en_drop", dport_enable, 1'b0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
